// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the crossing-detector state encoding.
// Ports: none (package).
// Holds FP_W, FP_EXP_MAX, the cross_state_t enum and a NaN test helper.
package fpu_pkg;

  localparam int          FP_W       = 32;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ABOVE = 2'd1,
    ST_BELOW = 2'd2
  } cross_state_t;

  // Exponent all ones with a nonzero mantissa; infinities are not NaN.
  function automatic logic fp_is_nan(input logic [FP_W-1:0] f);
    return (f[30:23] == FP_EXP_MAX) && (f[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_gt.sv
// Purpose: combinational IEEE-754 single compare, out = f1 > f2 (strict).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: f1, f2 operands; out high when f1 is strictly greater than f2.
module fp_gt
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] f1,
  input  logic [FP_W-1:0] f2,
  output logic            out
);

  logic        w_nan_any;
  logic        w_both_zero;
  logic [30:0] w_mag1;
  logic [30:0] w_mag2;

  assign w_mag1      = f1[30:0];
  assign w_mag2      = f2[30:0];
  assign w_nan_any   = fp_is_nan(f1) || fp_is_nan(f2);
  // +0 and -0 compare equal, so neither is greater than the other.
  assign w_both_zero = (w_mag1 == 31'd0) && (w_mag2 == 31'd0);

  always_comb begin
    out = 1'b0;
    if (w_nan_any || w_both_zero) begin
      out = 1'b0;
    end else if (f1[31] != f2[31]) begin
      out = ~f1[31];
    end else if (!f1[31]) begin
      out = (w_mag1 > w_mag2);
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      out = (w_mag1 < w_mag2);
    end
  end

endmodule

// File: rtl/fp_cross_detect.sv
// Purpose: debounced threshold-crossing detector on a float price stream.
// Latency: 1 cycle, all outputs registered. Backpressure: none; thr_load wins over in_valid.
// Ports: clk, rst (sync, active-high), thr_load/thr_in threshold load, in_valid/price samples;
//        cross_up/cross_down/nan_err/sample_drop one-cycle pulses, above and state levels.
module fp_cross_detect
  import fpu_pkg::*;
#(
  parameter int CONFIRM_N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            thr_load,
  input  logic [FP_W-1:0] thr_in,
  input  logic            in_valid,
  input  logic [FP_W-1:0] price,
  output logic            cross_up,
  output logic            cross_down,
  output logic            above,
  output logic [1:0]      state,
  output logic            nan_err,
  output logic            sample_drop
);

  localparam int              CNT_W   = $clog2(CONFIRM_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(CONFIRM_N);

  cross_state_t     r_state;
  cross_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [FP_W-1:0]  r_thr;
  logic [FP_W-1:0]  w_thr_nxt;
  logic             r_cross_up,  w_cross_up;
  logic             r_cross_dn,  w_cross_dn;
  logic             r_nan_err,   w_nan_err;
  logic             r_drop,      w_drop;
  logic             r_above;
  logic             w_gt;
  logic             w_nan;

  fp_gt u_fp_gt (
    .f1  (price),
    .f2  (r_thr),
    .out (w_gt)
  );

  assign w_nan     = fp_is_nan(price);
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_thr_nxt   = r_thr;
    w_cross_up  = 1'b0;
    w_cross_dn  = 1'b0;
    w_nan_err   = 1'b0;
    w_drop      = 1'b0;

    if (thr_load) begin
      // New threshold invalidates any side history; a same-cycle sample is dropped.
      w_thr_nxt   = thr_in;
      w_state_nxt = ST_INIT;
      w_cnt_nxt   = '0;
      w_drop      = in_valid;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (in_valid && !w_nan) begin
            w_state_nxt = w_gt ? ST_ABOVE : ST_BELOW;
            w_cnt_nxt   = '0;
          end
        end
        ST_ABOVE: begin
          if (in_valid && !w_nan) begin
            if (w_gt) begin
              w_cnt_nxt = '0;
            end else if (w_cnt_inc == CNT_TGT) begin
              w_state_nxt = ST_BELOW;
              w_cnt_nxt   = '0;
              w_cross_dn  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        ST_BELOW: begin
          if (in_valid && !w_nan) begin
            if (!w_gt) begin
              w_cnt_nxt = '0;
            end else if (w_cnt_inc == CNT_TGT) begin
              w_state_nxt = ST_ABOVE;
              w_cnt_nxt   = '0;
              w_cross_up  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to INIT and start over.
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      endcase
      w_nan_err = in_valid && w_nan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_thr      <= '0;
      r_cross_up <= 1'b0;
      r_cross_dn <= 1'b0;
      r_nan_err  <= 1'b0;
      r_drop     <= 1'b0;
      r_above    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_thr      <= w_thr_nxt;
      r_cross_up <= w_cross_up;
      r_cross_dn <= w_cross_dn;
      r_nan_err  <= w_nan_err;
      r_drop     <= w_drop;
      r_above    <= (w_state_nxt == ST_ABOVE);
    end
  end

  assign cross_up    = r_cross_up;
  assign cross_down  = r_cross_dn;
  assign above       = r_above;
  assign state       = r_state;
  assign nan_err     = r_nan_err;
  assign sample_drop = r_drop;

endmodule
